// File: rtl/resp_trace_capture.sv
// resp_trace_capture: capture side of the stimulus-replay path.
// While armed, samples a DUT output vector every clock, packs it into
// {run_len, value} entries and stores them in a small FIFO. The FIFO is
// drained through a valid/ready read port.
//
// Build option: define TRACE_RLE_EN to run-length encode equal samples.
// Without it, every captured sample becomes its own entry with run_len = 1.
// The entry width is the same in both builds.
module resp_trace_capture #(
  parameter int DATA_W = 6,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     arm,
  input  logic                     stop,
  input  logic                     clear,
  input  logic [DATA_W-1:0]        sample_in,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [CNT_W+DATA_W-1:0]  rd_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     busy,
  output logic                     overflow
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int ENTRY_W = CNT_W + DATA_W;

  localparam logic [CNT_W-1:0] RUN_MAX    = '1;
  localparam logic [CNT_W-1:0] RUN_ONE    = CNT_W'(1);
  localparam logic [PTR_W:0]   LEVEL_FULL = (PTR_W+1)'(DEPTH);

`ifdef TRACE_RLE_EN
  localparam bit RLE_EN = 1'b1;
`else
  localparam bit RLE_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPTURE,
    S_DONE
  } state_t;

  // Control state
  state_t             state_q, state_d;
  logic               first_q, first_d;   // first CAPTURE cycle: load only
  logic [DATA_W-1:0]  cur_q, cur_d;       // value of the pending run
  logic [CNT_W-1:0]   run_q, run_d;       // length of the pending run
  logic               overflow_q, overflow_d;

  // FIFO storage
  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]     level_q;

  // Handshake / push qualification
  logic               push;
  logic [ENTRY_W-1:0] push_entry;
  logic               pop;
  logic               drop;
  logic               push_ok;

  assign pop     = (level_q != '0) && rd_ready;
  // A push into a full FIFO only survives if the head leaves on the same edge.
  assign drop    = (level_q == LEVEL_FULL) && !pop;
  assign push_ok = push && !drop;

  // Next-state and capture datapath decisions.
  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    first_d    = first_q;
    cur_d      = cur_q;
    run_d      = run_q;
    overflow_d = overflow_q;
    push       = 1'b0;
    push_entry = {run_q, cur_q};

    unique case (state_q)
      S_IDLE: begin
        // stop is meaningless before a capture has started
        if (arm) begin
          state_d = S_CAPTURE;
          first_d = 1'b1;
        end
      end

      S_CAPTURE: begin
        if (stop) begin
          // Flush the pending run; the sample on this cycle is not recorded.
          // Nothing is pending yet if stop lands on the load cycle.
          state_d = S_DONE;
          push    = !first_q;
          first_d = 1'b0;
        end else if (first_q) begin
          cur_d   = sample_in;
          run_d   = RUN_ONE;
          first_d = 1'b0;
        end else if (RLE_EN && (sample_in == cur_q) && (run_q != RUN_MAX)) begin
          run_d = run_q + 1'b1;
        end else begin
          push  = 1'b1;
          cur_d = sample_in;
          run_d = RUN_ONE;
        end

        // A dropped entry ends the capture; the pending run is abandoned.
        if (push && drop) begin
          state_d    = S_DONE;
          overflow_d = 1'b1;
          first_d    = 1'b0;
        end
      end

      S_DONE: begin
        // Re-arming keeps the stored trace but forgets the old overflow.
        if (arm) begin
          state_d    = S_CAPTURE;
          first_d    = 1'b1;
          overflow_d = 1'b0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Synchronous flush outranks everything except reset.
    if (clear) begin
      state_d    = S_IDLE;
      first_d    = 1'b0;
      cur_d      = '0;
      run_d      = '0;
      overflow_d = 1'b0;
      push       = 1'b0;
    end
  end

  // Control and pending-run registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      first_q    <= 1'b0;
      cur_q      <= '0;
      run_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      first_q    <= first_d;
      cur_q      <= cur_d;
      run_q      <= run_d;
      overflow_q <= overflow_d;
    end
  end

  // FIFO pointers and occupancy; clear empties the queue on the next edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      unique case ({push_ok, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // FIFO storage write port.
  // NOTE: the array is not reset; level/pointers decide what is valid and
  // rd_data is forced to zero when empty, so stale contents never escape.
  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem[wr_ptr_q] <= push_entry;
    end
  end

  // Output decode; registered FIFO, so a push shows up one cycle later.
  always_comb begin
    rd_valid = (level_q != '0);
    rd_data  = rd_valid ? mem[rd_ptr_q] : '0;
  end

  assign level    = level_q;
  assign busy     = (state_q == S_CAPTURE);
  assign overflow = overflow_q;

endmodule
